// File: rtl/display_scan_serializer.sv
// Scans the five display channels in turn and shifts each 16-bit word
// {0, channel, value} out MSB first on a divided serial clock, then latches it.
module display_scan_serializer #(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [2:0]  sel,
  input  logic [11:0] mux_data,
  output logic        ser_clk,
  output logic        ser_data,
  output logic        ser_latch,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_CAPTURE,
    S_SHIFT,
    S_LATCH,
    S_DWELL
  } state_t;

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  localparam logic [2:0]  LAST_CHAN  = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  chan_q, chan_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic        phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] shreg_q, shreg_d;
  logic        frame_done_d;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    cnt_d        = cnt_q + 16'd1;
    div_d        = div_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        chan_d = '0;
        if (enable) state_d = S_SELECT;
      end
      // Two clocks here give the external mux register time to follow sel.
      S_SELECT: begin
        if (cnt_q == 16'd1) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        state_d = S_SHIFT;
        shreg_d = {1'b0, chan_q, mux_data};
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = '0;
        cnt_d   = '0;
      end
      // Each bit is a low half then a high half; data moves on the high->low turn.
      S_SHIFT: begin
        cnt_d = '0;
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == 4'd15) begin
              state_d = S_LATCH;
              shreg_d = '0;
            end else begin
              bit_d   = bit_q + 4'd1;
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_LATCH: begin
        if (cnt_q == {8'd0, DIV_LAST}) begin
          state_d = S_DWELL;
          cnt_d   = '0;
        end
      end
      S_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d        = '0;
          frame_done_d = (chan_q == LAST_CHAN);
          chan_d       = (chan_q == LAST_CHAN) ? 3'd0 : chan_q + 3'd1;
          if (enable) begin
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
            chan_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        chan_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      chan_q     <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      phase_q    <= 1'b0;
      bit_q      <= '0;
      shreg_q    <= '0;
      sel        <= '0;
      ser_clk    <= 1'b0;
      ser_data   <= 1'b0;
      ser_latch  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      sel        <= (state_d == S_IDLE) ? 3'd0 : chan_d;
      ser_clk    <= (state_d == S_SHIFT) && phase_d;
      ser_data   <= (state_d == S_SHIFT) && shreg_d[15];
      ser_latch  <= (state_d == S_LATCH);
      busy       <= (state_d != S_IDLE);
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: doc/display_scan_serializer.md
DISPLAY_SCAN_SERIALIZER -- requirements
Module: display_scan_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: system clocks per ser_clk half-period; legal range 1..255.
REQ-002 SHALL have parameter DWELL, default 4: idle clocks after each latch before the next channel; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  system clock (wb_clk_i at top level); all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  level; 1 = run channel scan, 0 = stop at the next word boundary.
REQ-006 SHALL have port sel  output  3  channel select to the 5:1 display mux: 0 voltage, 1 current, 2 power, 3 temperature, 4 efficiency.
REQ-007 SHALL have port mux_data  input  12  registered mux output; valid 1 clock after sel changes.
REQ-008 SHALL have port ser_clk  output  1  serial display clock; idle low.
REQ-009 SHALL have port ser_data  output  1  serial data, MSB first; idle low.
REQ-010 SHALL have port ser_latch  output  1  word-latch strobe to the display driver.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port frame_done  output  1  one-clock pulse after channel 4's dwell completes.

Function
REQ-013 SHALL implement the FSM IDLE, SELECT, CAPTURE, SHIFT, LATCH, DWELL.
REQ-014 IDLE SHALL move to SELECT on the first clock with enable=1, with channel counter at 0.
REQ-015 SELECT SHALL drive sel=channel and last exactly 2 clocks, covering the mux register latency.
REQ-016 CAPTURE SHALL last 1 clock and load the shift register with word = {1'b0, channel[2:0], mux_data[11:0]} (16 bits).
REQ-017 SHIFT SHALL send 16 bits MSB first; each bit is CLK_DIV clocks with ser_clk=0 followed by CLK_DIV clocks with ser_clk=1.
REQ-018 ser_data SHALL change only on the first clock of the low phase of each bit; SHIFT SHALL last 32*CLK_DIV clocks.
REQ-019 LATCH SHALL hold ser_latch=1 for CLK_DIV clocks, with ser_clk=0 and ser_data=0.
REQ-020 DWELL SHALL last DWELL clocks; on exit, channel SHALL advance as 0->1->2->3->4->0 (wrap after 4; values 5-7 never occur).
REQ-021 On DWELL exit with channel=4, frame_done SHALL pulse high for exactly 1 clock, coincident with the first clock of the next state.
REQ-022 On DWELL exit, enable=1 SHALL go to SELECT; enable=0 SHALL go to IDLE with channel reset to 0.
REQ-023 enable deasserting in SELECT..DWELL SHALL NOT abort the word; the word completes through LATCH and DWELL.
REQ-024 sel SHALL remain stable from SELECT entry through DWELL exit; in IDLE sel SHALL be 0.
REQ-025 Per-channel period SHALL be 3 + 33*CLK_DIV + DWELL clocks (73 at defaults); frame period 5x that (365 at defaults).
REQ-026 mux_data SHALL be sampled only in CAPTURE; changes at any other time SHALL NOT affect the word in flight.
REQ-027 Bit and divider counters SHALL be sized for the maximum parameter values, with no overflow at CLK_DIV=255 or DWELL=65535.
REQ-028 All outputs SHALL be driven from registers (no combinational path from input to output).

Reset
REQ-029 While rst_n=0, the block SHALL immediately and asynchronously force: state=IDLE, channel=0, sel=0, ser_clk=0, ser_data=0, ser_latch=0, busy=0, frame_done=0, shift register=0.
REQ-030 Reset asserted mid-word SHALL abandon the word; no partial latch pulse SHALL be emitted.
REQ-031 After rst_n release, the first state change SHALL occur on the first rising clk edge with enable=1.

Verification
REQ-032 Defaults, mux model returning 0xA5C for sel=0, enable=1 -> ser_data bits 0000_1010_0101_1100, 16 ser_clk rising edges, ser_latch high 2 clocks, first SELECT of channel 1 at clock 73.
REQ-033 Full frame with distinct per-channel values -> words carry channel IDs 0..4 in order, frame_done pulses once at clock 365, then channel 0 repeats.
REQ-034 enable dropped 10 clocks into the channel-2 SHIFT -> channel 2 word completes with latch, busy falls after DWELL, sel=0, no frame_done.
REQ-035 rst_n pulsed low during bit 7 of SHIFT -> all outputs 0 in the same clock, no ser_latch, restart sends channel 0.
REQ-036 mux_data toggled every clock except during CAPTURE -> transmitted word equals the value present in CAPTURE.
REQ-037 CLK_DIV=1, DWELL=1 -> channel period 37 clocks, ser_clk period 2 clocks, no bit slips.
